// File: rtl/state_mem_sweep_ctrl.sv
// Write-side controller for a one-bit-per-line cache valid memory: fill/invalidate writes plus a swept flush.
// Latency: one cycle from accepted request (or flush start) to the registered memory write.
// Backpressure: READY drops during flush request, sweep and done; requesters hold VALID until accepted.
module state_mem_sweep_ctrl #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              FLUSH_REQ,
  output logic              FLUSH_BUSY,
  output logic              FLUSH_DONE,
  input  logic              FILL_VALID,
  input  logic [ADDR_W-1:0] FILL_ADDR,
  output logic              FILL_READY,
  input  logic              INV_VALID,
  input  logic [ADDR_W-1:0] INV_ADDR,
  output logic              INV_READY,
  output logic              MEM_WREN,
  output logic [ADDR_W-1:0] MEM_WADDR,
  output logic              MEM_DATA
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_wren;
  logic              w_wren_nxt;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] w_waddr_nxt;
  logic              r_data;
  logic              w_data_nxt;
  logic              w_inv_rdy;
  logic              w_fill_rdy;

  // State, sweep counter and the registered memory write port.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_wren  <= 1'b0;
      r_waddr <= '0;
      r_data  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wren  <= w_wren_nxt;
      r_waddr <= w_waddr_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Next state, arbitration (flush > invalidate > fill) and next write; the
  // write registered with each sweep step is the line the counter points at
  // while in SWEEP, so the counter and MEM_WADDR stay aligned.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wren_nxt  = 1'b0;
    w_waddr_nxt = r_waddr;
    w_data_nxt  = r_data;
    w_inv_rdy   = 1'b0;
    w_fill_rdy  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_inv_rdy  = !FLUSH_REQ;
        w_fill_rdy = !FLUSH_REQ && !INV_VALID;
        if (FLUSH_REQ) begin
          w_state_nxt = ST_SWEEP;
          w_cnt_nxt   = '0;
          w_wren_nxt  = 1'b1;
          w_waddr_nxt = '0;
          w_data_nxt  = 1'b0;
        end else if (INV_VALID) begin
          w_wren_nxt  = 1'b1;
          w_waddr_nxt = INV_ADDR;
          w_data_nxt  = 1'b0;
        end else if (FILL_VALID) begin
          w_wren_nxt  = 1'b1;
          w_waddr_nxt = FILL_ADDR;
          w_data_nxt  = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (r_cnt == LAST_LINE) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + ONE;
          w_wren_nxt  = 1'b1;
          w_waddr_nxt = r_cnt + ONE;
          w_data_nxt  = 1'b0;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign FLUSH_BUSY = (r_state != ST_IDLE);
  assign FLUSH_DONE = (r_state == ST_DONE);
  assign INV_READY  = w_inv_rdy;
  assign FILL_READY = w_fill_rdy;
  assign MEM_WREN   = r_wren;
  assign MEM_WADDR  = r_waddr;
  assign MEM_DATA   = r_data;

endmodule

// File: tb/tb_state_mem_sweep_ctrl.sv
// Bench for state_mem_sweep_ctrl with an 8-line memory: directed scenarios then random traffic.
// Reference model tracks sweep position as a plain integer and predicts each cycle's write.
// Requesters hold VALID until the model says the request was accepted.
module tb_state_mem_sweep_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          FLUSH_REQ;
  logic          FLUSH_BUSY;
  logic          FLUSH_DONE;
  logic          FILL_VALID;
  logic [AW-1:0] FILL_ADDR;
  logic          FILL_READY;
  logic          INV_VALID;
  logic [AW-1:0] INV_ADDR;
  logic          INV_READY;
  logic          MEM_WREN;
  logic [AW-1:0] MEM_WADDR;
  logic          MEM_DATA;

  state_mem_sweep_ctrl #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .FLUSH_REQ(FLUSH_REQ), .FLUSH_BUSY(FLUSH_BUSY), .FLUSH_DONE(FLUSH_DONE),
    .FILL_VALID(FILL_VALID), .FILL_ADDR(FILL_ADDR), .FILL_READY(FILL_READY),
    .INV_VALID(INV_VALID), .INV_ADDR(INV_ADDR), .INV_READY(INV_READY),
    .MEM_WREN(MEM_WREN), .MEM_WADDR(MEM_WADDR), .MEM_DATA(MEM_DATA)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: m_pos = -1 idle, 0..DEPTH-1 sweeping that line, DEPTH = done cycle.
  int       m_pos = -1;
  bit       e_wren = 1'b0;
  int       e_waddr = 0;
  bit       e_data = 1'b0;
  int       n_done = 0;

  // Requester side (held until accepted).
  bit       fl = 1'b0;
  bit       p_iv = 1'b0;
  int       p_ia = 0;
  bit       p_fv = 1'b0;
  int       p_fa = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_write(input int addr, input bit data);
    e_wren  = 1'b1;
    e_waddr = addr;
    e_data  = data;
  endtask

  // One clock: drive requests, check outputs against the model, advance the model.
  task automatic tick();
    bit idle;
    bit e_irdy;
    bit e_frdy;
    @(negedge CLK);
    FLUSH_REQ  = fl;
    INV_VALID  = p_iv;
    INV_ADDR   = AW'(p_ia);
    FILL_VALID = p_fv;
    FILL_ADDR  = AW'(p_fa);
    #1;
    idle   = (m_pos < 0);
    e_irdy = idle && !fl;
    e_frdy = e_irdy && !p_iv;
    chk("inv_ready",  32'(INV_READY),  32'(e_irdy));
    chk("fill_ready", 32'(FILL_READY), 32'(e_frdy));
    chk("mem_wren",   32'(MEM_WREN),   32'(e_wren));
    chk("mem_waddr",  32'(MEM_WADDR),  32'(e_waddr));
    if (e_wren) chk("mem_data", 32'(MEM_DATA), 32'(e_data));
    chk("flush_busy", 32'(FLUSH_BUSY), 32'(m_pos >= 0));
    chk("flush_done", 32'(FLUSH_DONE), 32'(m_pos == DEPTH));
    if (m_pos == DEPTH) n_done++;
    e_wren = 1'b0;
    if (idle) begin
      if (fl) begin
        m_pos = 0;
        do_write(0, 1'b0);
      end else if (p_iv) begin
        do_write(p_ia, 1'b0);
        p_iv = 1'b0;
      end else if (p_fv) begin
        do_write(p_fa, 1'b1);
        p_fv = 1'b0;
      end
    end else if (m_pos < DEPTH - 1) begin
      m_pos = m_pos + 1;
      do_write(m_pos, 1'b0);
    end else if (m_pos == DEPTH - 1) begin
      m_pos = DEPTH;
    end else begin
      m_pos = -1;
    end
    fl = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    @(negedge CLK);
    #2;
    RSTN = 1'b0;
    #1;
    chk("rst_wren",  32'(MEM_WREN),   32'd0);
    chk("rst_waddr", 32'(MEM_WADDR),  32'd0);
    chk("rst_data",  32'(MEM_DATA),   32'd0);
    chk("rst_busy",  32'(FLUSH_BUSY), 32'd0);
    chk("rst_done",  32'(FLUSH_DONE), 32'd0);
    m_pos = -1; e_wren = 1'b0; e_waddr = 0; e_data = 1'b0;
    p_iv = 1'b0; p_fv = 1'b0; fl = 1'b0;
    FLUSH_REQ = 1'b0; INV_VALID = 1'b0; FILL_VALID = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  initial begin
    int done_before;
    RSTN = 1'b0;
    FLUSH_REQ = 1'b0; INV_VALID = 1'b0; INV_ADDR = '0;
    FILL_VALID = 1'b0; FILL_ADDR = '0;
    #1;
    chk("init_wren",  32'(MEM_WREN),   32'd0);
    chk("init_waddr", 32'(MEM_WADDR),  32'd0);
    chk("init_data",  32'(MEM_DATA),   32'd0);
    chk("init_busy",  32'(FLUSH_BUSY), 32'd0);
    chk("init_done",  32'(FLUSH_DONE), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;

    // Idle with no requests: both readies high, nothing written.
    run(2);

    // Single fill to line 5.
    p_fv = 1'b1; p_fa = 5;
    run(3);

    // Invalidate 7 and fill 9 (wraps to line 1 with 8 lines) held together.
    p_iv = 1'b1; p_ia = 7; p_fv = 1'b1; p_fa = 9 % DEPTH;
    run(4);

    // Full sweep with a second flush request ignored mid-sweep.
    fl = 1'b1;
    run(3);
    fl = 1'b1;
    done_before = n_done;
    run(9);
    chk("sweep_done_count", 32'(n_done - done_before), 32'd1);

    // Flush and invalidate in the same cycle: sweep first, then the held invalidate.
    fl = 1'b1; p_iv = 1'b1; p_ia = 3;
    run(13);

    // Reset during the sweep at line 4, then a fresh sweep from line 0.
    fl = 1'b1;
    run(5);
    done_before = n_done;
    async_reset();
    run(3);
    chk("abort_no_done", 32'(n_done - done_before), 32'd0);
    fl = 1'b1;
    run(12);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (!p_iv && $urandom_range(0, 2) == 0) begin
        p_iv = 1'b1; p_ia = $urandom_range(0, DEPTH - 1);
      end
      if (!p_fv && $urandom_range(0, 1) == 0) begin
        p_fv = 1'b1; p_fa = $urandom_range(0, DEPTH - 1);
      end
      if ($urandom_range(0, 24) == 0) fl = 1'b1;
      tick();
    end
    run(DEPTH + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/state_mem_sweep_ctrl.md
Name: state_mem_sweep_ctrl

Overview:
- Write-side controller for a cache line valid-bit (state) memory, one bit per line.
- Arbitrates single-line fill writes (set valid) and invalidate writes (clear valid) from the cache FSM.
- Performs a full flush as a sequenced sweep that clears one line per cycle, instead of a single-cycle bulk clear.
- Drives the memory's write enable, write address and write data; signals busy/done to the cache control.

Parameters:
- DEPTH, 512, number of cache lines (entries in the state memory); power of two, >= 2.
- ADDR_W, $clog2(DEPTH), line index width.

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RSTN  input  1  asynchronous, active-low reset.
- FLUSH_REQ  input  1  single-cycle pulse; starts a full sweep.
- FLUSH_BUSY  output  1  high while a sweep or its done cycle is in progress.
- FLUSH_DONE  output  1  one-cycle pulse when the sweep completes.
- FILL_VALID  input  1  request to mark line FILL_ADDR valid.
- FILL_ADDR  input  ADDR_W  line index for fill.
- FILL_READY  output  1  fill accepted when VALID & READY.
- INV_VALID  input  1  request to mark line INV_ADDR invalid.
- INV_ADDR  input  ADDR_W  line index for invalidate.
- INV_READY  output  1  invalidate accepted when VALID & READY.
- MEM_WREN  output  1  state memory write enable.
- MEM_WADDR  output  ADDR_W  state memory write address.
- MEM_DATA  output  1  state bit to write (1 = valid, 0 = invalid).

Behaviour:
- One clock; reset is asynchronous and active-low. RSTN low immediately forces state IDLE, sweep counter 0, and all outputs 0.
- MEM_WREN, MEM_WADDR and MEM_DATA are registered. FLUSH_BUSY and FLUSH_DONE are decoded from state.
- FSM states: IDLE, SWEEP, DONE.
- IDLE, readiness (combinational):
  - INV_READY = !FLUSH_REQ.
  - FILL_READY = !FLUSH_REQ & !INV_VALID.
  - Priority is FLUSH > INV > FILL.
- IDLE, accepted request:
  - An accepted INV at edge t gives MEM_WREN=1, MEM_WADDR=INV_ADDR, MEM_DATA=0 during cycle t+1.
  - An accepted FILL gives the same, with MEM_DATA=1.
  - Otherwise MEM_WREN=0 next cycle.
  - Latency is one cycle. Back-to-back accepts give a write every cycle.
- IDLE, FLUSH_REQ high:
  - Go to SWEEP; counter is 0.
  - Any same-cycle INV/FILL is not accepted (READY low) and must be held by the requester.
- SWEEP:
  - Each cycle, register MEM_WREN=1, MEM_WADDR=counter, MEM_DATA=0, then counter+1.
  - When counter==DEPTH-1 is issued, go to DONE. The counter wraps to 0.
  - FILL_READY=INV_READY=0. FLUSH_REQ is ignored, with no queuing.
- DONE: FLUSH_DONE=1 for exactly one cycle; MEM_WREN=0; next state IDLE. READY stays low in DONE.
- FLUSH_BUSY = (state != IDLE).
- Sweep timing: FLUSH_REQ sampled at edge 0 gives writes to addresses 0..DEPTH-1 on cycles 1..DEPTH, FLUSH_DONE on cycle DEPTH+1, and FLUSH_BUSY high on cycles 1..DEPTH+1.
- A pending fill or invalidate to a line is never lost: the requester holds VALID until READY.
- Reset mid-sweep aborts it: no FLUSH_DONE is produced, and the counter restarts at 0 on the next FLUSH_REQ.
- MEM_WADDR holds its last value when MEM_WREN=0; only MEM_WREN qualifies writes.

Test Plan:
- Reset, then idle: all outputs 0; FILL_READY=INV_READY=1 with no requests.
- FILL_VALID=1, FILL_ADDR=5 for one cycle -> next cycle MEM_WREN=1, MEM_WADDR=5, MEM_DATA=1; following cycle MEM_WREN=0.
- INV_VALID and FILL_VALID both high (INV_ADDR=7, FILL_ADDR=9), held -> first write is addr 7 data 0 (FILL_READY=0), then addr 9 data 1.
- DEPTH=8, FLUSH_REQ pulse -> MEM_WREN=1 on 8 consecutive cycles, addresses 0..7, data 0; FLUSH_DONE on cycle 9; FLUSH_BUSY high cycles 1..9; READYs low throughout; a second FLUSH_REQ during the sweep has no effect.
- FLUSH_REQ and INV_VALID (addr 3) in the same cycle, INV held -> sweep runs first; INV accepted in the first IDLE cycle after DONE, writing addr 3 data 0.
- RSTN asserted at sweep address 4 (DEPTH=8) -> outputs 0 immediately, no FLUSH_DONE; a new FLUSH_REQ after release restarts at address 0.
